thor2024_fetch_buffer: RTL and testbench
========================================

Name: thor2024_fetch_buffer

Overview:
Double-pair instruction fetch buffer sitting between the I-cache/PC register and the dispatch/enqueue stage. It holds two pairs of fetched instructions: pair P0 = slots A,B and pair P1 = slots C,D. It selects the current pair for dispatch, and detects predicted-taken backward branches. It produces the fetchbuf select, the per-slot valid bits, the backbr flags, backpc and did_branchback consumed by the PC register.

Parameters:
PC_W, 32, program-counter width.
INSN_W, 40, instruction width in bits.
INSN_BYTES, 5, byte stride between the two instructions of a fetched pair.
BR_LO, 7'h28, lowest conditional-branch opcode (insn[6:0]).
BR_HI, 7'h2F, highest conditional-branch opcode.
DISP_LSB, 25, LSB of the branch displacement field; the field spans [INSN_W-1:DISP_LSB] and its MSB is the sign.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_v  in  1  I-cache hit and no irq; a fetched pair is available
fetch_pc  in  PC_W  address of first instruction of pair
fetch_insn0  in  INSN_W  instruction at fetch_pc
fetch_insn1  in  INSN_W  instruction at fetch_pc+INSN_BYTES
fetch_ack  out  1  pair accepted this cycle (combinational)
deq_cnt  in  2  instructions taken from current pair this cycle (0..2)
branchmiss  in  1  flush all slots
fetchbuf  out  1  current pair: 0=P0(A,B), 1=P1(C,D)
fetchbufA_v..fetchbufD_v  out  1 each  slot valid
backbrA..backbrD  out  1 each  slot valid and holds a backward branch (combinational)
fb0_v, fb0_pc, fb0_insn  out  1/PC_W/INSN_W  first slot of current pair
fb1_v, fb1_pc, fb1_insn  out  1/PC_W/INSN_W  second slot of current pair
branchback  out  1  backbr asserted on a valid slot of current pair
backpc  out  PC_W  target of the oldest backward branch in current pair
did_branchback  out  1  stomp already performed for current pair

Behaviour:
- Reset: all four valid bits 0, fetchbuf=0, did_branchback=0. Stored pc/insn registers are don't-care. All outputs derived from valids read 0.
- Backward branch decode per slot: BR_LO<=insn[6:0]<=BR_HI and displacement MSB=1. backbrX = valid & decode.
- backpc = slot pc + sign-extended displacement, taken from the first slot of the current pair if it is backbr, else from the second.
- Fill (uses pre-dequeue state):
  - If fetch_v and A,B both invalid: load P0 (A=insn0, B=insn1; pc, pc+INSN_BYTES) and set both valids.
  - Else if fetch_v and C,D both invalid: load P1 the same way.
  - Else no load.
  - fetch_ack=1 iff a load occurs.
  - This is the same condition the PC register uses to advance.
- Dequeue on current pair:
  - deq_cnt=1 clears the first valid slot (A before B, C before D).
  - deq_cnt=2 clears both slots.
  - deq_cnt greater than the valid count clears only the valid slots (clamp).
  - If the current pair is empty after dequeue, fetchbuf toggles the next cycle.
  - If both pairs are empty, fetchbuf stays.
- Stomp:
  - If the first valid slot of the current pair is backbr and did_branchback=0: clear the second slot of the pair and clear the whole other pair. Set did_branchback=1.
  - If only the second slot is backbr: clear the other pair only and set did_branchback=1.
  - A fill in the same cycle into the other pair is suppressed (fetch_ack=0).
- did_branchback clears when fetchbuf toggles or on branchmiss.
- branchmiss has priority over fill, dequeue and stomp:
  - Next cycle: all valids 0, fetchbuf=0, did_branchback=0.
  - fetch_ack=0 in the branchmiss cycle.
- fb0/fb1 mux from fetchbuf with one-cycle registered state, no extra latency. A fetched pair is visible on fb0/fb1 the cycle after fetch_ack.
- Latency from fetch to dispatch-visible: 1 cycle. Throughput: 2 instructions/cycle when dispatch takes 2.

Test Plan:
- Reset, then fetch_v=1 with pc=0x1000 -> next cycle A,B valid, fb0_pc=0x1000, fb1_pc=0x1005, fetchbuf=0. With deq_cnt=0, next fetch fills C,D; a third fetch gets fetch_ack=0.
- P0 and P1 full, deq_cnt=2 -> A,B cleared, fetchbuf=1 next cycle, fb0_pc=C pc. With fetch_v=1 in the following cycle, P0 refills.
- deq_cnt=1 twice on P0 -> first A cleared with fetchbuf held, then B cleared and fetchbuf toggles.
- A holds a branch opcode 7'h28 with disp=-0x20 at pc=0x2000 -> backbrA=1, backpc=0x1FE0, B and C,D cleared, did_branchback=1. A second cycle with the same state must not re-stomp.
- Only B is backbr and P1 is valid -> P1 cleared, A and B retained, branchback=1.
- branchmiss together with fetch_v=1 and deq_cnt=2 -> all valids 0, fetchbuf=0, fetch_ack=0. A rst pulse mid-stream likewise zeroes all valids.

Source files
------------

// File: rtl/thor2024_fetch_buffer.sv
// Double-pair fetch buffer: holds P0 (A,B) and P1 (C,D), presents the
// current pair to dispatch and stomps younger slots on backward branches.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_v/pc/insn0/1  fetched pair from the I-cache
//   fetch_ack           pair loaded this cycle (PC register advances on it)
//   deq_cnt             instructions taken from the current pair (0..2)
//   branchmiss          flush every slot
//   fetchbuf            current pair select (0=P0, 1=P1)
//   fetchbufA_v..D_v    per-slot valid
//   backbrA..D          slot valid and holding a backward branch
//   fb0_*, fb1_*        first/second slot of the current pair
//   branchback, backpc  backward branch in current pair and its target
//   did_branchback      stomp already done for the current pair
module thor2024_fetch_buffer #(
  parameter int         PC_W       = 32,
  parameter int         INSN_W     = 40,
  parameter int         INSN_BYTES = 5,
  parameter logic [6:0] BR_LO      = 7'h28,
  parameter logic [6:0] BR_HI      = 7'h2F,
  parameter int         DISP_LSB   = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_v,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic [INSN_W-1:0] fetch_insn0,
  input  logic [INSN_W-1:0] fetch_insn1,
  output logic              fetch_ack,
  input  logic [1:0]        deq_cnt,
  input  logic              branchmiss,
  output logic              fetchbuf,
  output logic              fetchbufA_v,
  output logic              fetchbufB_v,
  output logic              fetchbufC_v,
  output logic              fetchbufD_v,
  output logic              backbrA,
  output logic              backbrB,
  output logic              backbrC,
  output logic              backbrD,
  output logic              fb0_v,
  output logic [PC_W-1:0]   fb0_pc,
  output logic [INSN_W-1:0] fb0_insn,
  output logic              fb1_v,
  output logic [PC_W-1:0]   fb1_pc,
  output logic [INSN_W-1:0] fb1_insn,
  output logic              branchback,
  output logic [PC_W-1:0]   backpc,
  output logic              did_branchback
);

  localparam int DISP_W = INSN_W - DISP_LSB;

  logic [PC_W-1:0]   a_pc, b_pc, c_pc, d_pc;
  logic [INSN_W-1:0] a_insn, b_insn, c_insn, d_insn;

  function automatic logic is_bb(
    input logic [INSN_W-1:0] i
  );
    return (i[6:0] >= BR_LO) &&
           (i[6:0] <= BR_HI) &&
           i[INSN_W-1];
  endfunction

  function automatic logic [PC_W-1:0] tgt(
    input logic [PC_W-1:0]   pc,
    input logic [INSN_W-1:0] i
  );
    return pc + {{(PC_W-DISP_W){i[INSN_W-1]}},
                 i[INSN_W-1:DISP_LSB]};
  endfunction

  assign backbrA = fetchbufA_v & is_bb(a_insn);
  assign backbrB = fetchbufB_v & is_bb(b_insn);
  assign backbrC = fetchbufC_v & is_bb(c_insn);
  assign backbrD = fetchbufD_v & is_bb(d_insn);

  assign fb0_v    = fetchbuf ? fetchbufC_v : fetchbufA_v;
  assign fb0_pc   = fetchbuf ? c_pc : a_pc;
  assign fb0_insn = fetchbuf ? c_insn : a_insn;
  assign fb1_v    = fetchbuf ? fetchbufD_v : fetchbufB_v;
  assign fb1_pc   = fetchbuf ? d_pc : b_pc;
  assign fb1_insn = fetchbuf ? d_insn : b_insn;

  logic bb0, bb1;
  assign bb0 = fetchbuf ? backbrC : backbrA;
  assign bb1 = fetchbuf ? backbrD : backbrB;

  assign branchback = bb0 | bb1;
  assign backpc = bb0 ? tgt(fb0_pc, fb0_insn)
                      : tgt(fb1_pc, fb1_insn);

  // Oldest backward branch in the current pair wins; everything
  // younger than it is discarded once per pair.
  logic stomp0, stomp1, stomp;
  assign stomp0 = bb0 & ~did_branchback;
  assign stomp1 = ~bb0 & bb1 & ~did_branchback;
  assign stomp  = stomp0 | stomp1;

  logic p0_empty, p1_empty;
  assign p0_empty = ~fetchbufA_v & ~fetchbufB_v;
  assign p1_empty = ~fetchbufC_v & ~fetchbufD_v;

  // A stomp needs a valid current slot, so any fill then
  // would land in the other pair being discarded.
  assign fetch_ack = fetch_v & ~branchmiss & ~stomp &
                     (p0_empty | p1_empty);

  logic load0, load1;
  assign load0 = fetch_ack & p0_empty;
  assign load1 = fetch_ack & ~p0_empty;

  // deq_cnt=1 takes the first valid slot; 2 or more clamps to both.
  logic clr0, clr1;
  assign clr0 = |deq_cnt;
  assign clr1 = deq_cnt[1] |
                ((deq_cnt == 2'd1) & ~fb0_v) |
                stomp0;

  logic a_n, b_n, c_n, d_n;
  assign a_n = (fetchbufA_v & ~(fetchbuf ? stomp : clr0)) | load0;
  assign b_n = (fetchbufB_v & ~(fetchbuf ? stomp : clr1)) | load0;
  assign c_n = (fetchbufC_v & ~(fetchbuf ? clr0 : stomp)) | load1;
  assign d_n = (fetchbufD_v & ~(fetchbuf ? clr1 : stomp)) | load1;

  logic cur_empty_n, oth_busy_n, toggle;
  assign cur_empty_n = fetchbuf ? ~(c_n | d_n) : ~(a_n | b_n);
  assign oth_busy_n  = fetchbuf ? (a_n | b_n) : (c_n | d_n);
  assign toggle      = cur_empty_n & oth_busy_n;

  always_ff @(posedge clk) begin
    if (rst | branchmiss) begin
      fetchbufA_v    <= 1'b0;
      fetchbufB_v    <= 1'b0;
      fetchbufC_v    <= 1'b0;
      fetchbufD_v    <= 1'b0;
      fetchbuf       <= 1'b0;
      did_branchback <= 1'b0;
    end else begin
      fetchbufA_v <= a_n;
      fetchbufB_v <= b_n;
      fetchbufC_v <= c_n;
      fetchbufD_v <= d_n;
      if (toggle)
        fetchbuf <= ~fetchbuf;
      // Any empty current pair means the next one is a fresh pair.
      did_branchback <= ~cur_empty_n &
                        (did_branchback | stomp);
    end
  end

  always_ff @(posedge clk) begin
    if (load0) begin
      a_pc   <= fetch_pc;
      a_insn <= fetch_insn0;
      b_pc   <= fetch_pc + PC_W'(INSN_BYTES);
      b_insn <= fetch_insn1;
    end
    if (load1) begin
      c_pc   <= fetch_pc;
      c_insn <= fetch_insn0;
      d_pc   <= fetch_pc + PC_W'(INSN_BYTES);
      d_insn <= fetch_insn1;
    end
  end

endmodule

// File: tb/tb_thor2024_fetch_buffer.sv
// Directed bench for thor2024_fetch_buffer with a dispatch scoreboard.
// Ports: none (drives and checks the DUT internally).
module tb_thor2024_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_v;
  logic [31:0] fetch_pc;
  logic [39:0] fetch_insn0, fetch_insn1;
  logic        fetch_ack;
  logic [1:0]  deq_cnt;
  logic        branchmiss;
  logic        fetchbuf;
  logic        fa_v, fb_v, fc_v, fd_v;
  logic        bbA, bbB, bbC, bbD;
  logic        fb0_v, fb1_v;
  logic [31:0] fb0_pc, fb1_pc;
  logic [39:0] fb0_insn, fb1_insn;
  logic        branchback;
  logic [31:0] backpc;
  logic        did;

  always #5 clk = ~clk;

  thor2024_fetch_buffer dut (
    .clk(clk), .rst(rst),
    .fetch_v(fetch_v), .fetch_pc(fetch_pc),
    .fetch_insn0(fetch_insn0), .fetch_insn1(fetch_insn1),
    .fetch_ack(fetch_ack), .deq_cnt(deq_cnt),
    .branchmiss(branchmiss), .fetchbuf(fetchbuf),
    .fetchbufA_v(fa_v), .fetchbufB_v(fb_v),
    .fetchbufC_v(fc_v), .fetchbufD_v(fd_v),
    .backbrA(bbA), .backbrB(bbB),
    .backbrC(bbC), .backbrD(bbD),
    .fb0_v(fb0_v), .fb0_pc(fb0_pc), .fb0_insn(fb0_insn),
    .fb1_v(fb1_v), .fb1_pc(fb1_pc), .fb1_insn(fb1_insn),
    .branchback(branchback), .backpc(backpc),
    .did_branchback(did)
  );

  int vec = 0;
  int miss = 0;
  logic [71:0] sb[$];

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc,
                       input logic [39:0] i0, input logic [39:0] i1,
                       input logic [1:0] dq, input logic bm);
    fetch_v     = fv;
    fetch_pc    = pc;
    fetch_insn0 = i0;
    fetch_insn1 = i1;
    deq_cnt     = dq;
    branchmiss  = bm;
    #1;
  endtask

  task automatic fetch_chk(input logic exp_ack);
    chk("fetch_ack", 80'(fetch_ack), 80'(exp_ack));
    if (exp_ack) begin
      sb.push_back({fetch_pc, fetch_insn0});
      sb.push_back({fetch_pc + 32'd5, fetch_insn1});
    end
  endtask

  task automatic pop_chk(input logic slot1);
    logic [71:0] e;
    if (sb.size() == 0) begin
      vec++;
      miss++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if (slot1)
        chk("fb1", {fb1_v, fb1_pc, fb1_insn}, {1'b1, e});
      else
        chk("fb0", {fb0_v, fb0_pc, fb0_insn}, {1'b1, e});
    end
  endtask

  task automatic vchk(input string tag, input logic [3:0] v,
                      input logic fbuf);
    chk(tag, {fa_v, fb_v, fc_v, fd_v, fetchbuf}, {v, fbuf});
  endtask

  function automatic logic [39:0] p(input int k);
    return {32'hA000_0000 | 32'(k), 8'h01};
  endfunction

  function automatic logic [39:0] br(input logic [6:0] op,
                                     input logic [14:0] disp);
    return {disp, 18'h0, op};
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset", {fa_v, fb_v, fc_v, fd_v, fetchbuf, did,
                  fb0_v, fb1_v, branchback}, 80'd0);

    // fill P0 then P1, third fetch refused
    drive(1, 32'h1000, p(0), p(1), 0, 0);
    fetch_chk(1);
    tick();
    vchk("fill_p0", 4'b1100, 0);
    chk("fb_pcs", {fb0_pc, fb1_pc}, {32'h1000, 32'h1005});
    drive(1, 32'h100A, p(2), p(3), 0, 0);
    fetch_chk(1);
    tick();
    vchk("fill_p1", 4'b1111, 0);
    drive(1, 32'h1014, p(4), p(5), 0, 0);
    fetch_chk(0);
    tick();
    vchk("full", 4'b1111, 0);

    // dispatch two, toggle, refill P0
    drive(0, 0, 0, 0, 2, 0);
    pop_chk(0);
    pop_chk(1);
    tick();
    vchk("deq2", 4'b0011, 1);
    chk("fb0_pc_p1", 80'(fb0_pc), 80'h100A);
    drive(1, 32'h1014, p(4), p(5), 0, 0);
    fetch_chk(1);
    tick();
    vchk("refill_p0", 4'b1111, 1);
    drive(0, 0, 0, 0, 2, 0);
    pop_chk(0);
    pop_chk(1);
    tick();
    vchk("deq2_p1", 4'b1100, 0);
    drive(1, 32'h101E, p(6), p(7), 0, 0);
    fetch_chk(1);
    tick();
    vchk("refill_p1", 4'b1111, 0);

    // single dequeues
    drive(0, 0, 0, 0, 1, 0);
    pop_chk(0);
    tick();
    vchk("deq1_a", 4'b0111, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("fb0_v_gone", 80'(fb0_v), 80'd0);
    pop_chk(1);
    tick();
    vchk("deq1_b", 4'b0011, 1);
    drive(0, 0, 0, 0, 2, 0);
    pop_chk(0);
    pop_chk(1);
    tick();
    vchk("all_empty", 4'b0000, 1);
    chk("sb_drained", 80'(sb.size()), 80'd0);

    // backward branch in A (B also a branch: A has priority)
    drive(1, 32'h2000, br(7'h28, 15'h7FE0),
          br(7'h28, 15'h7FC0), 0, 0);
    fetch_chk(1);
    tick();
    vchk("br_fill", 4'b1100, 0);
    drive(1, 32'h3000, p(8), p(9), 0, 0);
    chk("bbA", {bbA, bbB, branchback, did}, 4'b1110);
    chk("backpc_a", 80'(backpc), 80'h1FE0);
    fetch_chk(0);
    tick();
    void'(sb.pop_back());
    vchk("stomp_a", 4'b1000, 0);
    chk("did_set", 80'(did), 80'd1);
    drive(1, 32'h3000, p(8), p(9), 0, 0);
    fetch_chk(1);
    tick();
    vchk("no_restomp", 4'b1011, 0);
    chk("did_hold", {did, bbA}, 2'b11);
    drive(0, 0, 0, 0, 1, 0);
    pop_chk(0);
    tick();
    vchk("deq_br", 4'b0011, 1);
    chk("did_clr", 80'(did), 80'd0);
    drive(0, 0, 0, 0, 3, 0);
    pop_chk(0);
    pop_chk(1);
    tick();
    vchk("deq_clamp", 4'b0000, 1);

    // backward branch only in B
    drive(1, 32'h4000, p(10), br(7'h2F, 15'h7EFB), 0, 0);
    fetch_chk(1);
    tick();
    drive(1, 32'h5000, p(11), p(12), 0, 0);
    chk("bbB", {bbA, bbB, branchback}, 3'b011);
    chk("backpc_b", 80'(backpc), 80'h3F00);
    fetch_chk(0);
    tick();
    vchk("stomp_b", 4'b1100, 0);
    chk("did_b", 80'(did), 80'd1);
    drive(1, 32'h5000, p(11), p(12), 0, 0);
    fetch_chk(1);
    tick();
    vchk("keep_p1", 4'b1111, 0);
    drive(0, 0, 0, 0, 2, 0);
    pop_chk(0);
    pop_chk(1);
    tick();
    vchk("deq_b", 4'b0011, 1);

    // branchmiss beats fill and dequeue
    drive(1, 32'h6000, p(13), p(14), 2, 1);
    fetch_chk(0);
    tick();
    sb.delete();
    vchk("bmiss", 4'b0000, 0);
    chk("bmiss_did", 80'(did), 80'd0);

    // reset mid-stream
    drive(1, 32'h7000, p(15), p(16), 0, 0);
    fetch_chk(1);
    tick();
    drive(1, 32'h700A, p(17), p(18), 0, 0);
    fetch_chk(1);
    tick();
    vchk("pre_rst", 4'b1111, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    sb.delete();
    vchk("mid_rst", 4'b0000, 0);
    chk("mid_rst_bb", {bbA, bbB, bbC, bbD, branchback}, 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
